// File: rtl/game_sprite_pkg.sv
// Shared types and constants for the sprite display read path.
package game_sprite_pkg;

    localparam int unsigned SPRITE_W_DEF = 8;
    localparam int unsigned SPRITE_H_DEF = 8;
    localparam int unsigned RGB_WIDTH    = 3;

    localparam int unsigned ROM_COL_W = $clog2(SPRITE_W_DEF);
    localparam int unsigned ROM_ROW_W = $clog2(SPRITE_H_DEF);

    // Colour value that means "no sprite pixel here".
    localparam logic [RGB_WIDTH-1:0] TRANSPARENT = '0;

    // Bitmap address: row within sprite, column within sprite.
    typedef struct packed {
        logic [ROM_ROW_W-1:0] row;
        logic [ROM_COL_W-1:0] col;
    } sprite_addr_t;

endpackage

// File: rtl/game_sprite_rom.sv
// Combinational sprite bitmap: (row, col) -> colour, colour 0 is transparent.
module game_sprite_rom
    import game_sprite_pkg::*;
(
    input  sprite_addr_t         addr,
    output logic [RGB_WIDTH-1:0] colour
);

    localparam int unsigned ROW_BITS_W = SPRITE_W_DEF * RGB_WIDTH;

    logic [ROW_BITS_W-1:0] row_bits;
    logic [ROW_BITS_W-1:0] shifted;

    // One octal digit per pixel, column 0 in the most significant digit.
    always_comb begin
        row_bits = '0;
        case (addr.row)
            3'd0: row_bits = 24'o12033025;
            3'd1: row_bits = 24'o01233210;
            3'd2: row_bits = 24'o00444400;
            3'd3: row_bits = 24'o60477406;
            3'd4: row_bits = 24'o60477406;
            3'd5: row_bits = 24'o00444400;
            3'd6: row_bits = 24'o01022010;
            3'd7: row_bits = 24'o30011003;
            default: row_bits = '0;
        endcase
        shifted = row_bits << (RGB_WIDTH * int'(addr.col));
        colour  = shifted[ROW_BITS_W-1 -: RGB_WIDTH];
    end

endmodule

// File: rtl/game_sprite_display.sv
// Sprite read path: frame-latched coordinates, 2-cycle pixel pipeline,
// per-frame collision report against another layer.
// Optional build macro GAME_SPRITE_MIRROR_EN adds sprite_flip_x (horizontal mirror).
module game_sprite_display #(
    parameter int unsigned SPRITE_WIDTH  = game_sprite_pkg::SPRITE_W_DEF,
    parameter int unsigned SPRITE_HEIGHT = game_sprite_pkg::SPRITE_H_DEF,
    parameter int unsigned screen_width  = 640,
    parameter int unsigned screen_height = 480,
    parameter int unsigned w_x           = $clog2(screen_width),
    parameter int unsigned w_y           = $clog2(screen_height),
    parameter int unsigned RGB_WIDTH     = game_sprite_pkg::RGB_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 display_on,
    input  logic [w_x-1:0]       x,
    input  logic [w_y-1:0]       y,
    input  logic [w_x-1:0]       sprite_x,
    input  logic [w_y-1:0]       sprite_y,
`ifdef GAME_SPRITE_MIRROR_EN
    input  logic                 sprite_flip_x,
`endif
    input  logic                 other_en,
    output logic [RGB_WIDTH-1:0] rgb,
    output logic                 rgb_en,
    output logic                 collision,
    output logic                 collision_valid
);

    import game_sprite_pkg::*;

    localparam int unsigned XW = w_x + 1;
    localparam int unsigned YW = w_y + 1;

    // Frame-latched sprite position
    logic [w_x-1:0] lat_x_q, lat_x_d;
    logic [w_y-1:0] lat_y_q, lat_y_d;
    logic           lat_valid_q, lat_valid_d;
`ifdef GAME_SPRITE_MIRROR_EN
    logic           lat_flip_q, lat_flip_d;
`endif

    // Stage 1
    logic           s1_in_box_q, s1_in_box_d;
    sprite_addr_t   s1_addr_q, s1_addr_d;

    // Stage 2 / outputs
    logic [RGB_WIDTH-1:0] rgb_q, rgb_d;
    logic                 rgb_en_q, rgb_en_d;
    logic                 acc_q, acc_d;
    logic                 collision_q, collision_d;
    logic                 collision_valid_q, collision_valid_d;

    logic                 fb_c;
    logic                 hit_c;
    logic [XW-1:0]        x_e_c, lat_x_e_c, x_end_c;
    logic [YW-1:0]        y_e_c, lat_y_e_c, y_end_c;
    logic                 in_box_c;
    logic [ROM_COL_W-1:0] col_raw_c, col_c;
    logic [ROM_ROW_W-1:0] row_c;
    logic [RGB_WIDTH-1:0] rom_colour_c;
    logic [RGB_WIDTH-1:0] colour_c;

    game_sprite_rom u_rom (
        .addr   (s1_addr_q),
        .colour (rom_colour_c)
    );

    // Next-state: coordinate latch, box test, colour stage, collision accumulator.
    always_comb begin
        lat_x_d           = lat_x_q;
        lat_y_d           = lat_y_q;
        lat_valid_d       = lat_valid_q;
`ifdef GAME_SPRITE_MIRROR_EN
        lat_flip_d        = lat_flip_q;
`endif
        acc_d             = acc_q;
        collision_d       = collision_q;
        collision_valid_d = 1'b0;

        fb_c  = (x == '0) && (y == w_y'(screen_height));
        hit_c = rgb_en_q && other_en;

        // Widened compares so the sprite end never wraps at the screen edge.
        x_e_c     = XW'(x);
        lat_x_e_c = XW'(lat_x_q);
        x_end_c   = lat_x_e_c + XW'(SPRITE_WIDTH);
        y_e_c     = YW'(y);
        lat_y_e_c = YW'(lat_y_q);
        y_end_c   = lat_y_e_c + YW'(SPRITE_HEIGHT);

        in_box_c = display_on && lat_valid_q &&
                   (x_e_c >= lat_x_e_c) && (x_e_c < x_end_c) &&
                   (y_e_c >= lat_y_e_c) && (y_e_c < y_end_c);

        col_raw_c = ROM_COL_W'(x - lat_x_q);
        row_c     = ROM_ROW_W'(y - lat_y_q);
        col_c     = col_raw_c;
`ifdef GAME_SPRITE_MIRROR_EN
        if (lat_flip_q) begin
            col_c = ROM_COL_W'(SPRITE_WIDTH - 1) - col_raw_c;
        end
`endif

        s1_in_box_d   = in_box_c;
        s1_addr_d.row = row_c;
        s1_addr_d.col = col_c;

        colour_c = RGB_WIDTH'(rom_colour_c);
        rgb_en_d = s1_in_box_q && (colour_c != RGB_WIDTH'(TRANSPARENT));
        rgb_d    = rgb_en_d ? colour_c : '0;

        if (fb_c) begin
            lat_x_d           = sprite_x;
            lat_y_d           = sprite_y;
            lat_valid_d       = 1'b1;
`ifdef GAME_SPRITE_MIRROR_EN
            lat_flip_d        = sprite_flip_x;
`endif
            collision_d       = acc_q | hit_c;
            acc_d             = 1'b0;
            collision_valid_d = 1'b1;
        end else begin
            acc_d = acc_q | hit_c;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_x_q           <= '0;
            lat_y_q           <= '0;
            lat_valid_q       <= 1'b0;
`ifdef GAME_SPRITE_MIRROR_EN
            lat_flip_q        <= 1'b0;
`endif
            s1_in_box_q       <= 1'b0;
            s1_addr_q         <= '0;
            rgb_q             <= '0;
            rgb_en_q          <= 1'b0;
            acc_q             <= 1'b0;
            collision_q       <= 1'b0;
            collision_valid_q <= 1'b0;
        end else begin
            lat_x_q           <= lat_x_d;
            lat_y_q           <= lat_y_d;
            lat_valid_q       <= lat_valid_d;
`ifdef GAME_SPRITE_MIRROR_EN
            lat_flip_q        <= lat_flip_d;
`endif
            s1_in_box_q       <= s1_in_box_d;
            s1_addr_q         <= s1_addr_d;
            rgb_q             <= rgb_d;
            rgb_en_q          <= rgb_en_d;
            acc_q             <= acc_d;
            collision_q       <= collision_d;
            collision_valid_q <= collision_valid_d;
        end
    end

    assign rgb             = rgb_q;
    assign rgb_en          = rgb_en_q;
    assign collision       = collision_q;
    assign collision_valid = collision_valid_q;

endmodule

// File: tb/tb_game_sprite_display.sv
// Directed bench for game_sprite_display: cycle model plus hand-computed checkpoints.
module tb_game_sprite_display;

    logic       clk;
    logic       rst;
    logic       display_on;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       other_en;
    logic [2:0] rgb;
    logic       rgb_en;
    logic       collision;
    logic       collision_valid;
`ifdef GAME_SPRITE_MIRROR_EN
    logic       sprite_flip_x;
    logic       tb_flip;
`endif

    game_sprite_display dut (
        .clk             (clk),
        .rst             (rst),
        .display_on      (display_on),
        .x               (x),
        .y               (y),
        .sprite_x        (sprite_x),
        .sprite_y        (sprite_y),
`ifdef GAME_SPRITE_MIRROR_EN
        .sprite_flip_x   (sprite_flip_x),
`endif
        .other_en        (other_en),
        .rgb             (rgb),
        .rgb_en          (rgb_en),
        .collision       (collision),
        .collision_valid (collision_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int en_count = 0;

    // Scenario-side controls, applied to the DUT at the next step
    logic tb_rst = 1'b1;
    logic tb_other = 1'b0;
    int   tb_sx = 0;
    int   tb_sy = 0;

    // Reference model state
    int   m_lat_x = 0, m_lat_y = 0;
    logic m_lat_v = 1'b0, m_flip = 1'b0;
    logic s1_en = 1'b0, o_en = 1'b0;
    int   s1_rgb = 0, o_rgb = 0;
    logic m_acc = 1'b0, m_coll = 1'b0, m_cv = 1'b0;

    // Reference bitmap, one digit per pixel, column 0 first
    string bm [8] = '{"12033025", "01233210", "00444400", "60477406",
                      "60477406", "00444400", "01022010", "30011003"};

    function automatic int rom_px(input int r, input int c);
        string s;
        s = bm[r];
        return int'(s[c]) - 48;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs, drive new inputs, advance the model over the next edge.
    task automatic step(input logic don, input int xi, input int yi);
        logic hit, fb, inb;
        int   c, px;
        @(negedge clk);
        check_eq("rgb_en", 32'(rgb_en), 32'(o_en));
        check_eq("rgb", 32'(rgb), o_rgb);
        check_eq("collision_valid", 32'(collision_valid), 32'(m_cv));
        check_eq("collision", 32'(collision), 32'(m_coll));
        if (rgb_en) en_count++;
        rst        = tb_rst;
        other_en   = tb_other;
        sprite_x   = 10'(tb_sx);
        sprite_y   = 9'(tb_sy);
`ifdef GAME_SPRITE_MIRROR_EN
        sprite_flip_x = tb_flip;
`endif
        display_on = don;
        x          = 10'(xi);
        y          = 9'(yi);
        hit = o_en && tb_other;
        fb  = (xi == 0) && (yi == 480);
        if (tb_rst) begin
            m_lat_x = 0; m_lat_y = 0; m_lat_v = 1'b0; m_flip = 1'b0;
            s1_en = 1'b0; s1_rgb = 0; o_en = 1'b0; o_rgb = 0;
            m_acc = 1'b0; m_coll = 1'b0; m_cv = 1'b0;
        end else begin
            o_en  = s1_en;
            o_rgb = s1_rgb;
            inb = don && m_lat_v && xi >= m_lat_x && xi < m_lat_x + 8 &&
                  yi >= m_lat_y && yi < m_lat_y + 8;
            px = 0;
            if (inb) begin
                c  = xi - m_lat_x;
                if (m_flip) c = 7 - c;
                px = rom_px(yi - m_lat_y, c);
            end
            s1_en  = (px != 0);
            s1_rgb = px;
            if (fb) begin
                m_coll  = m_acc | hit;
                m_acc   = 1'b0;
                m_cv    = 1'b1;
                m_lat_x = tb_sx;
                m_lat_y = tb_sy;
                m_lat_v = 1'b1;
`ifdef GAME_SPRITE_MIRROR_EN
                m_flip  = tb_flip;
`endif
            end else begin
                m_acc = m_acc | hit;
                m_cv  = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 700, 0);
    endtask

    task automatic frame_boundary();
        step(1'b0, 0, 480);
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                step(xx < 640 && yy < 480, xx, yy);
    endtask

    initial begin
        rst = 1'b1; display_on = 1'b0; x = '0; y = '0;
        sprite_x = '0; sprite_y = '0; other_en = 1'b0;
`ifdef GAME_SPRITE_MIRROR_EN
        sprite_flip_x = 1'b0;
        tb_flip = 1'b0;
`endif

        // Reset state
        idle(3);
        check_eq("rst_rgb_en", 32'(rgb_en), 0);
        check_eq("rst_rgb", 32'(rgb), 0);
        check_eq("rst_collision", 32'(collision), 0);
        check_eq("rst_cvalid", 32'(collision_valid), 0);
        tb_rst = 1'b0;
        tb_sx = 100; tb_sy = 50;

        // Frame 0: nothing drawn before the first frame boundary
        en_count = 0;
        scan(90, 115, 45, 60);
        idle(2);
        check_eq("f0_no_draw", en_count, 0);
        frame_boundary();
        idle(1);
        check_eq("f0_cvalid", 32'(collision_valid), 1);
        check_eq("f0_collision", 32'(collision), 0);

        // Frame 1: all 40 opaque pixels drawn at (100,50)
        en_count = 0;
        scan(90, 115, 45, 60);
        idle(2);
        check_eq("f1_pixels", en_count, 40);

        // Latency and horizontal box edges
        step(1'b1, 99, 50);
        step(1'b1, 100, 50);
        step(1'b1, 108, 50);
        check_eq("x99_en", 32'(rgb_en), 0);
        check_eq("x99_rgb", 32'(rgb), 0);
        step(1'b1, 107, 50);
        check_eq("x100_en", 32'(rgb_en), 1);
        check_eq("x100_rgb", 32'(rgb), 1);
        step(1'b0, 700, 0);
        check_eq("x108_en", 32'(rgb_en), 0);
        check_eq("x108_rgb", 32'(rgb), 0);
        step(1'b0, 700, 0);
        check_eq("x107_rgb", 32'(rgb), 5);

        // Collision with one opaque pixel, reported at the frame boundary
        step(1'b1, 100, 50);
        idle(1);
        tb_other = 1'b1;
        idle(1);
        tb_other = 1'b0;
        frame_boundary();
        idle(1);
        check_eq("hit_cvalid", 32'(collision_valid), 1);
        check_eq("hit_collision", 32'(collision), 1);
        idle(1);
        check_eq("hit_cvalid_pulse", 32'(collision_valid), 0);

        // Frame without overlap reports no collision
        scan(95, 110, 50, 57);
        frame_boundary();
        idle(1);
        check_eq("nohit_collision", 32'(collision), 0);

        // Mid-frame coordinate change takes effect only at the next boundary
        en_count = 0;
        scan(95, 210, 50, 52);
        tb_sx = 200;
        scan(95, 210, 53, 57);
        idle(2);
        check_eq("midframe_pixels", en_count, 40);
        frame_boundary();
        en_count = 0;
        scan(95, 210, 50, 57);
        idle(2);
        check_eq("moved_pixels", en_count, 40);
        step(1'b1, 100, 50);
        idle(2);
        check_eq("old_pos_en", 32'(rgb_en), 0);
        step(1'b1, 200, 50);
        idle(2);
        check_eq("new_pos_rgb", 32'(rgb), 1);

        // Right edge: only columns 0..3 visible, no wrap to x=0
        tb_sx = 636;
        frame_boundary();
        en_count = 0;
        scan(630, 639, 50, 57);
        scan(0, 5, 50, 57);
        idle(2);
        check_eq("edge_pixels", en_count, 20);
        step(1'b1, 639, 50);
        step(1'b1, 0, 50);
        idle(1);
        check_eq("edge_x639_rgb", 32'(rgb), 3);
        idle(1);
        check_eq("edge_x0_en", 32'(rgb_en), 0);

        // Reset inside the sprite: dark until the next frame boundary
        tb_sx = 100;
        frame_boundary();
        scan(90, 115, 50, 51);
        scan(90, 102, 52, 52);
        tb_rst = 1'b1;
        step(1'b1, 103, 52);
        tb_rst = 1'b0;
        step(1'b1, 104, 52);
        check_eq("rst_mid_en", 32'(rgb_en), 0);
        check_eq("rst_mid_rgb", 32'(rgb), 0);
        en_count = 0;
        scan(105, 115, 52, 52);
        scan(90, 115, 53, 57);
        idle(2);
        check_eq("rst_mid_dark", en_count, 0);
        frame_boundary();
        idle(1);
        check_eq("rst_fb_cvalid", 32'(collision_valid), 1);
        step(1'b1, 100, 50);
        idle(2);
        check_eq("rst_resume_rgb", 32'(rgb), 1);

`ifdef GAME_SPRITE_MIRROR_EN
        // Mirrored sprite: column 7 appears at sprite_x
        tb_flip = 1'b1;
        frame_boundary();
        step(1'b1, 100, 50);
        step(1'b1, 107, 50);
        idle(1);
        check_eq("mirror_x100_rgb", 32'(rgb), 5);
        idle(1);
        check_eq("mirror_x107_rgb", 32'(rgb), 1);
`endif

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/game_sprite_display.md
Name: game_sprite_display

Overview:
- Read-side counterpart of the sprite position controller.
- Takes the current sprite_x/sprite_y from the controller and the raster scan position from the display timing block.
- Emits a per-pixel sprite colour and enable, with a fixed 2-cycle pipeline latency.
- Snapshots sprite coordinates once per frame, during vertical blanking, so the sprite never tears mid-frame. Also reports a per-frame collision flag against another layer.

Parameters:
- SPRITE_WIDTH, 8, sprite width in pixels.
- SPRITE_HEIGHT, 8, sprite height in pixels.
- screen_width, 640, visible pixels per line.
- screen_height, 480, visible lines per frame.
- w_x, $clog2(screen_width), scan/sprite x width.
- w_y, $clog2(screen_height), scan/sprite y width.
- RGB_WIDTH, 3, colour output width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- display_on  in  1  scan position is in the visible area.
- x  in  w_x  scan x.
- y  in  w_y  scan y; counts past screen_height during blanking.
- sprite_x  in  w_x  live sprite x from the controller.
- sprite_y  in  w_y  live sprite y from the controller.
- other_en  in  1  other layer drawing this pixel; aligned with rgb_en, not with x/y.
- rgb  out  RGB_WIDTH  sprite colour; 0 when rgb_en=0.
- rgb_en  out  1  sprite opaque pixel at scan position from 2 cycles earlier.
- collision  out  w=1  previous frame's sprite/other overlap result.
- collision_valid  out  1  one-cycle pulse when collision updates.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; every register is cleared on a rst-high clock edge.
- Reset values: rgb=0, rgb_en=0, collision=0, collision_valid=0, pipeline valid bits=0, latched coords=0, lat_valid=0.
- Frame boundary (fb): x==0 && y==screen_height.
  - On fb: lat_x<=sprite_x, lat_y<=sprite_y, lat_valid<=1.
  - Coordinates are never sampled at any other time.
- Stage 1, registered:
  - in_box = display_on && lat_valid && x>=lat_x && x<lat_x+SPRITE_WIDTH && y>=lat_y && y<lat_y+SPRITE_HEIGHT.
  - All compares and sums use w_x+1 / w_y+1 unsigned bits, so lat_x+SPRITE_WIDTH cannot wrap.
  - Register in_box, col=x-lat_x ($clog2(SPRITE_WIDTH) bits) and row=y-lat_y ($clog2(SPRITE_HEIGHT) bits).
- Stage 2, registered:
  - ROM lookup at (row,col) returns an RGB_WIDTH colour; TRANSPARENT=0.
  - rgb_en <= s1_in_box && colour!=0.
  - rgb <= rgb_en_next ? colour : 0.
- Latency: exactly 2 clocks from x/y to rgb/rgb_en, including across fb.
- Collision accumulator (acc):
  - acc <= acc | (rgb_en && other_en) every cycle.
  - On fb: collision <= acc | (rgb_en && other_en), then acc<=0, collision_valid<=1 for one cycle.
  - A hit in the fb cycle belongs to the frame being reported.
- Before the first fb after reset: no sprite drawn (lat_valid=0). collision_valid still pulses at the first fb, with collision=0.
- Sprite partly off the right/bottom edge: only visible pixels drawn, no wrap to the left/top.
- sprite_x/sprite_y changing mid-frame has no visible effect until the next fb.
- rst asserted mid-frame: outputs 0 on the next edge; drawing resumes only after the next fb.

Optional Feature:
- GAME_SPRITE_MIRROR_EN defined:
  - Extra input port sprite_flip_x (1 bit), latched at fb alongside the coords.
  - When the latched flip is 1, ROM column = SPRITE_WIDTH-1-col.
  - Intended to be driven from the sign of the controller's dx.
- Not defined: port absent, no mirroring, identical timing.

Decomposition:
- Package game_sprite_pkg: TRANSPARENT colour constant, default sprite dimensions, RGB_WIDTH, typedef for the (row,col) ROM address struct.
- One sub-module, game_sprite_rom: combinational SPRITE_HEIGHT x SPRITE_WIDTH bitmap, (row,col) -> colour. Stage-2 register lives in game_sprite_display.

Test Plan:
- Reset, then sprite_x=100/sprite_y=50 and a full frame scan -> no rgb_en in frame 0; first collision_valid pulse with collision=0; frame 1 rgb_en only for x in 100..107, y in 50..57, matching ROM non-zero pixels.
- Scan x=100,y=50 presented at cycle t -> rgb/rgb_en reflect ROM(0,0) at t+2; x=99 and x=108 -> rgb_en=0, rgb=0.
- sprite_x changed 100->200 at y=53 -> rest of the frame still draws at 100; the next frame draws at 200.
- sprite_x=636 (screen_width-4) -> only columns 0..3 drawn; nothing at x=0..3 of the same lines.
- other_en asserted overlapping one opaque pixel -> at the next fb, collision=1 and collision_valid pulses; following frame with no overlap -> collision=0.
- rst pulsed at y=52 inside the sprite -> rgb_en=0 from the next edge; no drawing until the following fb; with GAME_SPRITE_MIRROR_EN and sprite_flip_x=1, ROM(0,7) appears at x=sprite_x.
